sram_like_arbiter: RTL and testbench

- Merges the instruction-side and data-side SRAM-like master ports of the mips core onto one shared SRAM-like slave port. The slave port feeds either the single-port SRAM wrapper or cpu_axi_interface.
- Fixed priority: data port over instruction port. The grant is locked while a presented request is still unaccepted.
- Tracks accepted-but-unanswered transactions in an in-order ID FIFO. Each downstream data_ok/rdata is routed back to the master that issued it.

---
 rtl/sram_like_arbiter_pkg.sv | 18 +
 rtl/sram_like_arbiter_if.sv | 25 ++
 rtl/sram_like_id_fifo.sv | 56 +++++
 rtl/sram_like_arbiter.sv | 100 ++++++++++
 tb/tb_sram_like_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus: transfer sizes, requester IDs
// and the grant FSM state type used by sram_like_arbiter.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_HOLD_D,
        GNT_HOLD_I
    } gnt_state_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus bundle: req/wr/size/addr/wdata from master to slave,
// rdata/addr_ok/data_ok from slave to master. Modports: master, slave.
interface sram_like_if;
    import sram_like_pkg::*;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );

endinterface

// File: rtl/sram_like_id_fifo.sv
// In-order 1-bit ID FIFO of DEPTH entries (DEPTH a power of two).
// Ports: clk, rst (sync, active-high), push/din, pop/dout, count, full, empty.
module sram_like_id_fifo
    import sram_like_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             din,
    input  logic             pop,
    output logic             dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges inst and data SRAM-like masters onto one slave port; data wins,
// a presented-but-unaccepted grant is locked, responses routed by ID FIFO.
// Ports: clk, rst, inst/data (slave modports), m (master modport),
// busy (transactions outstanding), proto_err (sticky stray response).
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter  int OUTSTANDING = 4,
    localparam int CNT_W = $clog2(OUTSTANDING) + 1
) (
    input  logic         clk,
    input  logic         rst,
    sram_like_if.slave   inst,
    sram_like_if.slave   data,
    sram_like_if.master  m,
    output logic         busy,
    output logic         proto_err
);

    gnt_state_t       state;
    gnt_state_t       state_nxt;
    logic             sel_data;
    logic             sel_req;
    logic             presented;
    logic             accept;
    logic             pop;
    logic             head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GNT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        sel_data  = 1'b0;
        state_nxt = state;
        unique case (state)
            GNT_HOLD_D: sel_data = 1'b1;
            GNT_HOLD_I: sel_data = 1'b0;
            default:    sel_data = data.req;
        endcase
        sel_req   = sel_data ? data.req : inst.req;
        // A full FIFO withdraws the request but keeps any held grant.
        presented = sel_req && !full;
        accept    = presented && m.addr_ok;
        if (presented) begin
            if (m.addr_ok) begin
                state_nxt = GNT_IDLE;
            end else begin
                state_nxt = sel_data ? GNT_HOLD_D : GNT_HOLD_I;
            end
        end
    end

    assign m.req   = presented;
    assign m.wr    = sel_data ? data.wr    : inst.wr;
    assign m.size  = sel_data ? data.size  : inst.size;
    assign m.addr  = sel_data ? data.addr  : inst.addr;
    assign m.wdata = sel_data ? data.wdata : inst.wdata;

    assign inst.addr_ok = accept && !sel_data;
    assign data.addr_ok = accept && sel_data;

    assign pop          = m.data_ok && !empty;
    assign inst.data_ok = pop && (head == ID_INST);
    assign data.data_ok = pop && (head == ID_DATA);
    assign inst.rdata   = m.rdata;
    assign data.rdata   = m.rdata;

    assign busy = (count != '0);

    sram_like_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (sel_data ? ID_DATA : ID_INST),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (m.data_ok && empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs change 1 time unit after
// each rising edge, combinational outputs are checked 1 unit later.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    logic clk;
    logic rst;
    logic busy;
    logic proto_err;
    int   vectors;
    int   errs;

    sram_like_if inst_if ();
    sram_like_if data_if ();
    sram_like_if m_if ();

    sram_like_arbiter #(
        .OUTSTANDING (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst_if.slave),
        .data      (data_if.slave),
        .m         (m_if.master),
        .busy      (busy),
        .proto_err (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst = 1'b1;
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = SZ_WORD;
        inst_if.addr = '0; inst_if.wdata = '0;
        data_if.req = 0; data_if.wr = 0; data_if.size = SZ_WORD;
        data_if.addr = '0; data_if.wdata = '0;
        m_if.rdata = '0; m_if.addr_ok = 0; m_if.data_ok = 0;
        tick();
        tick();

        // Reset state
        chk("rst_m_req", m_if.req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_inst_aok", inst_if.addr_ok, 0);
        chk("rst_data_aok", data_if.addr_ok, 0);
        chk("rst_inst_dok", inst_if.data_ok, 0);
        chk("rst_data_dok", data_if.data_ok, 0);
        rst = 1'b0;
        tick();

        // Single inst read
        inst_if.req = 1; inst_if.addr = 32'hBFC0_0000;
        m_if.addr_ok = 1;
        #1;
        chk("t1_m_req", m_if.req, 1);
        chk("t1_m_addr", m_if.addr, 32'hBFC0_0000);
        chk("t1_inst_aok", inst_if.addr_ok, 1);
        chk("t1_data_aok", data_if.addr_ok, 0);
        tick();
        inst_if.req = 0; m_if.addr_ok = 0;
        m_if.data_ok = 1; m_if.rdata = 32'h3C1D_8000;
        #1;
        chk("t1_busy", busy, 1);
        chk("t1_inst_dok", inst_if.data_ok, 1);
        chk("t1_inst_rdata", inst_if.rdata, 32'h3C1D_8000);
        chk("t1_data_dok", data_if.data_ok, 0);
        tick();
        m_if.data_ok = 0;
        #1;
        chk("t1_idle_busy", busy, 0);

        // Simultaneous requests: data first
        inst_if.req = 1; inst_if.addr = 32'h0000_0A10;
        data_if.req = 1; data_if.addr = 32'h0000_0D10;
        m_if.addr_ok = 1;
        #1;
        chk("t2_data_aok0", data_if.addr_ok, 1);
        chk("t2_inst_aok0", inst_if.addr_ok, 0);
        chk("t2_m_addr0", m_if.addr, 32'h0000_0D10);
        tick();
        data_if.req = 0;
        m_if.data_ok = 1; m_if.rdata = 32'h11;
        #1;
        chk("t2_inst_aok1", inst_if.addr_ok, 1);
        chk("t2_m_addr1", m_if.addr, 32'h0000_0A10);
        chk("t2_data_dok1", data_if.data_ok, 1);
        chk("t2_inst_dok1", inst_if.data_ok, 0);
        chk("t2_data_rdata", data_if.rdata, 32'h11);
        tick();
        inst_if.req = 0; m_if.addr_ok = 0;
        m_if.data_ok = 1; m_if.rdata = 32'h22;
        #1;
        chk("t2_inst_dok2", inst_if.data_ok, 1);
        chk("t2_data_dok2", data_if.data_ok, 0);
        chk("t2_inst_rdata", inst_if.rdata, 32'h22);
        tick();
        m_if.data_ok = 0;
        #1;
        chk("t2_busy", busy, 0);

        // Grant lock
        inst_if.req = 1; inst_if.addr = 32'h0000_1000;
        #1;
        chk("t3_m_addr0", m_if.addr, 32'h0000_1000);
        chk("t3_inst_aok0", inst_if.addr_ok, 0);
        tick();
        data_if.req = 1; data_if.addr = 32'h0000_2000;
        #1;
        chk("t3_m_addr1", m_if.addr, 32'h0000_1000);
        chk("t3_data_aok1", data_if.addr_ok, 0);
        tick();
        #1;
        chk("t3_m_addr2", m_if.addr, 32'h0000_1000);
        tick();
        m_if.addr_ok = 1;
        #1;
        chk("t3_m_addr3", m_if.addr, 32'h0000_1000);
        chk("t3_inst_aok3", inst_if.addr_ok, 1);
        chk("t3_data_aok3", data_if.addr_ok, 0);
        tick();
        inst_if.req = 0;
        #1;
        chk("t3_data_aok4", data_if.addr_ok, 1);
        chk("t3_m_addr4", m_if.addr, 32'h0000_2000);
        tick();
        data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
        #1;
        chk("t3_inst_dok", inst_if.data_ok, 1);
        tick();
        #1;
        chk("t3_data_dok", data_if.data_ok, 1);
        tick();
        m_if.data_ok = 0;
        #1;
        chk("t3_busy", busy, 0);

        // Full FIFO
        m_if.addr_ok = 1;
        data_if.req = 1; data_if.wr = 1;
        for (int i = 0; i < 4; i++) begin
            data_if.addr = 32'h3000 + 32'(4 * i);
            data_if.wdata = 32'hA0 + 32'(i);
            #1;
            chk("t4_data_aok", data_if.addr_ok, 1);
            chk("t4_m_wr", m_if.wr, 1);
            tick();
        end
        data_if.addr = 32'h3010; data_if.wdata = 32'hA4;
        #1;
        chk("t4_full_m_req", m_if.req, 0);
        chk("t4_full_aok", data_if.addr_ok, 0);
        chk("t4_full_busy", busy, 1);
        tick();
        m_if.data_ok = 1;
        #1;
        chk("t4_pop_dok", data_if.data_ok, 1);
        chk("t4_pop_aok", data_if.addr_ok, 0);
        tick();
        m_if.data_ok = 0;
        #1;
        chk("t4_fifth_aok", data_if.addr_ok, 1);
        chk("t4_fifth_addr", m_if.addr, 32'h3010);
        tick();
        data_if.req = 0; data_if.wr = 0; m_if.addr_ok = 0;
        m_if.data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_drain_dok", data_if.data_ok, 1);
            tick();
        end
        m_if.data_ok = 0;
        #1;
        chk("t4_busy", busy, 0);

        // Wrap-around: push and pop in the same cycle
        m_if.addr_ok = 1;
        for (int k = 0; k <= 20; k++) begin
            inst_if.req  = (k < 20) && (k % 2 == 0);
            data_if.req  = (k < 20) && (k % 2 == 1);
            inst_if.addr = 32'h4000 + 32'(k);
            data_if.addr = 32'h5000 + 32'(k);
            m_if.data_ok = (k > 0);
            m_if.rdata   = 32'h100 + 32'(k - 1);
            #1;
            if (k < 20) begin
                chk("t5_inst_aok", inst_if.addr_ok, 32'(k % 2 == 0));
                chk("t5_data_aok", data_if.addr_ok, 32'(k % 2 == 1));
            end
            if (k > 0) begin
                chk("t5_inst_dok", inst_if.data_ok, 32'((k - 1) % 2 == 0));
                chk("t5_data_dok", data_if.data_ok, 32'((k - 1) % 2 == 1));
                chk("t5_rdata", data_if.rdata, 32'h100 + 32'(k - 1));
            end
            chk("t5_cnt_le1", 32'(dut.count <= 1), 1);
            tick();
        end
        inst_if.req = 0; data_if.req = 0;
        m_if.addr_ok = 0; m_if.data_ok = 0;
        #1;
        chk("t5_busy", busy, 0);

        // Stray response, then reset
        m_if.data_ok = 1; m_if.rdata = 32'hDEAD;
        #1;
        chk("t6_inst_dok", inst_if.data_ok, 0);
        chk("t6_data_dok", data_if.data_ok, 0);
        tick();
        m_if.data_ok = 0;
        #1;
        chk("t6_proto_err", proto_err, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("t6_rst_proto_err", proto_err, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_m_req", m_if.req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
